// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment display driver and capture blocks.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 8;
  localparam int unsigned SEL_W      = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned CHAR_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCEPT = 2'd2,
    ST_WAIT   = 2'd3
  } cap_state_e;

  // One synchronised bus sample: which digit is strobed and its normalised segments.
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [SEG_W-1:0] seg;
  } sample_t;

  // Active-high segment patterns, a=bit0 .. g=bit6.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [7:0] CHAR_SPACE   = 8'h20;
  localparam logic [7:0] CHAR_UNKNOWN = 8'h3F;

  // True when exactly one select line is active.
  function automatic logic sel_is_onehot(input logic [SEL_W-1:0] sel);
    return (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  endfunction

  // Index of the active line in a one-hot select; 0 for anything else.
  function automatic logic [IDX_W-1:0] sel_index(input logic [SEL_W-1:0] sel);
    logic [IDX_W-1:0] idx;
    idx = 2'd0;
    case (sel)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/four_char_capture_seg7_to_ascii.sv
// Combinational decode of an active-high 7-segment pattern to its ASCII character.
module seg7_to_ascii
  import display_pkg::*;
(
  input  logic [6:0]        pattern,
  output logic [CHAR_W-1:0] char_c,
  output logic              valid_c
);

  // Table lookup; unrecognised patterns report '?' and drop valid.
  always_comb begin
    char_c  = CHAR_UNKNOWN;
    valid_c = 1'b1;
    case (pattern)
      SEG_0:     char_c = 8'h30;
      SEG_1:     char_c = 8'h31;
      SEG_2:     char_c = 8'h32;
      SEG_3:     char_c = 8'h33;
      SEG_4:     char_c = 8'h34;
      SEG_5:     char_c = 8'h35;
      SEG_6:     char_c = 8'h36;
      SEG_7:     char_c = 8'h37;
      SEG_8:     char_c = 8'h38;
      SEG_9:     char_c = 8'h39;
      SEG_A:     char_c = 8'h41;
      SEG_B:     char_c = 8'h62;
      SEG_C:     char_c = 8'h43;
      SEG_D:     char_c = 8'h64;
      SEG_E:     char_c = 8'h45;
      SEG_F:     char_c = 8'h46;
      SEG_DASH:  char_c = 8'h2D;
      SEG_BLANK: char_c = CHAR_SPACE;
      default: begin
        char_c  = CHAR_UNKNOWN;
        valid_c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/four_char_capture.sv
// Captures a multiplexed four-digit 7-segment bus and decodes each digit back to ASCII.
module four_char_capture
  import display_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEG_W-1:0]  segments,
  input  logic [SEL_W-1:0]  digit_select,
  output logic [CHAR_W-1:0] digit0,
  output logic [CHAR_W-1:0] digit1,
  output logic [CHAR_W-1:0] digit2,
  output logic [CHAR_W-1:0] digit3,
  output logic [NUM_DIGITS-1:0] dp,
  output logic              frame_done,
  output logic              decode_err,
  output logic              stalled
);

  localparam int unsigned BUS_W = SEL_W + SEG_W;
  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  // A fresh sample either starts settling or, with a one-cycle settle, is accepted at once.
  localparam cap_state_e LOAD_STATE = (SETTLE_CYCLES == 1) ? ST_ACCEPT : ST_SETTLE;

  logic [BUS_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [SEL_W-1:0] sel_act;
  logic [SEG_W-1:0] seg_act;
  logic             sel_valid;
  sample_t          cur_sample;
  logic             same_sample;

  cap_state_e       state_q, state_d;
  sample_t          hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  tout_q, tout_d;
  logic [NUM_DIGITS-1:0][CHAR_W-1:0] digit_q, digit_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d;
  logic [NUM_DIGITS-1:0] seen_q, seen_d;
  logic [NUM_DIGITS-1:0] seen_next;
  logic             frame_done_q, frame_done_d;
  logic             decode_err_q, decode_err_d;
  logic             stalled_q, stalled_d;
  logic             load_sample;

  logic [CHAR_W-1:0] dec_char;
  logic              dec_valid;

  // Two-stage synchroniser feed for all select and segment pins.
  always_comb begin
    sync1_d = {digit_select, segments};
    sync2_d = sync1_q;
  end

  // Synchroniser flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sel_act     = SEL_ACTIVE_LOW ? ~sync2_q[BUS_W-1:SEG_W] : sync2_q[BUS_W-1:SEG_W];
  assign seg_act     = SEG_ACTIVE_LOW ? ~sync2_q[SEG_W-1:0]     : sync2_q[SEG_W-1:0];
  assign sel_valid   = sel_is_onehot(sel_act);
  assign cur_sample  = '{idx: sel_index(sel_act), seg: seg_act};
  assign same_sample = (cur_sample == hold_q);

  seg7_to_ascii u_decode (
    .pattern (hold_q.seg[6:0]),
    .char_c  (dec_char),
    .valid_c (dec_valid)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: settle on a stable sample, accept once, then wait for a change.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) state_d = LOAD_STATE;
      end
      ST_SETTLE: begin
        if (!sel_valid)                               state_d = ST_IDLE;
        else if (!same_sample)                        state_d = LOAD_STATE;
        else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1))  state_d = ST_ACCEPT;
      end
      ST_ACCEPT: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!sel_valid)        state_d = ST_IDLE;
        else if (!same_sample) state_d = LOAD_STATE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath: hold/count updates, digit write-back, frame and timeout tracking.
  always_comb begin
    hold_d       = hold_q;
    cnt_d        = cnt_q;
    digit_d      = digit_q;
    dp_d         = dp_q;
    seen_d       = seen_q;
    seen_next    = seen_q | (4'b0001 << hold_q.idx);
    frame_done_d = 1'b0;
    decode_err_d = decode_err_q;
    tout_d       = (tout_q == TO_W'(TIMEOUT_CYCLES)) ? tout_q : tout_q + TO_W'(1);

    load_sample = sel_valid &&
                  ((state_q == ST_IDLE) ||
                   (((state_q == ST_SETTLE) || (state_q == ST_WAIT)) && !same_sample));

    if (load_sample) begin
      hold_d = cur_sample;
      cnt_d  = CNT_W'(1);
    end else if ((state_q == ST_SETTLE) && sel_valid) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (state_q == ST_ACCEPT) begin
      digit_d[hold_q.idx] = dec_char;
      dp_d[hold_q.idx]    = hold_q.seg[7];
      tout_d              = '0;
      if (!dec_valid) decode_err_d = 1'b1;
      if (seen_next == 4'b1111) begin
        frame_done_d = 1'b1;
        seen_d       = '0;
      end else begin
        seen_d = seen_next;
      end
    end

    stalled_d = (tout_d == TO_W'(TIMEOUT_CYCLES));
  end

  // Datapath and registered output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q       <= '0;
      cnt_q        <= '0;
      tout_q       <= '0;
      digit_q      <= {NUM_DIGITS{CHAR_SPACE}};
      dp_q         <= '0;
      seen_q       <= '0;
      frame_done_q <= 1'b0;
      decode_err_q <= 1'b0;
      stalled_q    <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      tout_q       <= tout_d;
      digit_q      <= digit_d;
      dp_q         <= dp_d;
      seen_q       <= seen_d;
      frame_done_q <= frame_done_d;
      decode_err_q <= decode_err_d;
      stalled_q    <= stalled_d;
    end
  end

  assign digit0     = digit_q[0];
  assign digit1     = digit_q[1];
  assign digit2     = digit_q[2];
  assign digit3     = digit_q[3];
  assign dp         = dp_q;
  assign frame_done = frame_done_q;
  assign decode_err = decode_err_q;
  assign stalled    = stalled_q;

endmodule

// File: tb/tb_four_char_capture.sv
// Scoreboard bench for four_char_capture: random and directed bus scans against a dwell-level model.
module tb_four_char_capture;

  localparam int S  = 4;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] segments;
  logic [3:0] digit_select;
  logic [7:0] digit0, digit1, digit2, digit3;
  logic [3:0] dp;
  logic       frame_done, decode_err, stalled;

  always #5 clk = ~clk;

  four_char_capture #(
    .SETTLE_CYCLES (S),
    .SEG_ACTIVE_LOW(1'b1),
    .SEL_ACTIVE_LOW(1'b1),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .segments    (segments),
    .digit_select(digit_select),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .dp          (dp),
    .frame_done  (frame_done),
    .decode_err  (decode_err),
    .stalled     (stalled)
  );

  localparam logic [6:0] PAT [18] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F,
                                      7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h40, 7'h00};
  localparam logic [7:0] CHR [18] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                                      8'h39, 8'h41, 8'h62, 8'h43, 8'h64, 8'h45, 8'h46, 8'h2D, 8'h20};

  typedef struct packed {
    logic [31:0] digits;
    logic [3:0]  dpv;
    logic        err;
  } snap_t;

  snap_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    frames_seen = 0;

  // Reference state: what the display should show after each completed dwell.
  logic [7:0] m_dig [4];
  logic [3:0] m_dp, m_seen;
  logic       m_err;
  logic [3:0] prev_sel;
  logic [7:0] prev_seg;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 18; i++)
      if (PAT[i] == p) return {1'b1, CHR[i]};
    return {1'b0, 8'h3F};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_dig[i] = 8'h20;
    m_dp = 4'h0; m_seen = 4'h0; m_err = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_digits"}, {digit3, digit2, digit1, digit0}, {m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
    check({tag, "_dp"}, dp, m_dp);
    check({tag, "_err"}, decode_err, m_err);
  endtask

  // Hold one raw bus value for len cycles. Valid dwells are either short (< S) or long (>= S+2).
  task automatic dwell(input logic [3:0] sel_raw, input logic [7:0] seg_raw, input int len);
    logic [3:0] act_sel;
    logic [7:0] act_seg;
    logic [8:0] r;
    int         idx;
    act_sel = ~sel_raw;
    act_seg = ~seg_raw;
    if ($countones(act_sel) == 1 && len >= S + 2) begin
      idx = $clog2(act_sel);
      r = ref_decode(act_seg[6:0]);
      if (!r[8]) m_err = 1'b1;
      m_dig[idx]  = r[7:0];
      m_dp[idx]   = act_seg[7];
      m_seen[idx] = 1'b1;
      if (m_seen == 4'hF) begin
        exp_q.push_back('{digits: {m_dig[3], m_dig[2], m_dig[1], m_dig[0]}, dpv: m_dp, err: m_err});
        m_seen = 4'h0;
      end
    end
    digit_select = sel_raw;
    segments     = seg_raw;
    prev_sel     = sel_raw;
    prev_seg     = seg_raw;
    repeat (len) @(negedge clk);
  endtask

  task automatic strobe(input int n, input logic [6:0] pat, input logic dpb, input int len);
    logic [3:0] one;
    one = 4'(1) << n;
    dwell(~one, ~{dpb, pat}, len);
  endtask

  task automatic scan(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2, input logic [6:0] p3);
    strobe(0, p0, 1'b0, 16);
    strobe(1, p1, 1'b1, 16);
    strobe(2, p2, 1'b0, 16);
    strobe(3, p3, 1'b0, 16);
  endtask

  // Monitor: every frame_done pulse must match the next expected frame snapshot.
  always @(negedge clk) begin
    if (rst === 1'b0 && frame_done === 1'b1) begin
      frames_seen++;
      if (exp_q.size() == 0) begin
        check("frame_unexpected", 64'd1, 64'd0);
      end else begin
        snap_t e;
        e = exp_q.pop_front();
        check("frame_digits", {digit3, digit2, digit1, digit0}, e.digits);
        check("frame_dp", dp, e.dpv);
        check("frame_err", decode_err, e.err);
      end
    end
  end

  initial begin
    int f0;
    logic [3:0] sel;
    logic [7:0] seg;
    int len, kind;
    logic [3:0] bad_sel [5];
    bad_sel = '{4'hF, 4'h0, 4'hC, 4'h5, 4'h9};

    rst = 1'b1;
    digit_select = 4'hF;
    segments = 8'hFF;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_digits", {digit3, digit2, digit1, digit0}, 32'h20202020);
    check("reset_dp", dp, 4'h0);
    check("reset_frame", frame_done, 1'b0);
    check("reset_err", decode_err, 1'b0);
    check("reset_stalled", stalled, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Basic "0123" scan, twice.
    scan(7'h3F, 7'h06, 7'h5B, 7'h4F);
    scan(7'h3F, 7'h06, 7'h5B, 7'h4F);
    check("scan_digits", {digit3, digit2, digit1, digit0}, 32'h33323130);
    check("scan_err", decode_err, 1'b0);
    check_all("scan");

    // Ghosted select and a short wrong segment value must not be accepted.
    strobe(0, 7'h66, 1'b0, 16);
    dwell(4'b1100, 8'hFF, 2);
    strobe(1, 7'h7F, 1'b0, 3);
    strobe(1, 7'h6D, 1'b0, 16);
    dwell(4'b1100, 8'hC0, 2);
    strobe(2, 7'h7D, 1'b1, 16);
    strobe(3, 7'h07, 1'b0, 16);
    check("glitch_digits", {digit3, digit2, digit1, digit0}, 32'h37363534);
    check_all("glitch");

    // Unknown pattern on digit 2.
    strobe(2, 7'h55, 1'b0, 16);
    check("bad_digit2", digit2, 8'h3F);
    check("bad_err", decode_err, 1'b1);
    scan(7'h77, 7'h7C, 7'h39, 7'h5E);
    check("err_sticky", decode_err, 1'b1);
    check_all("sticky");

    // Digit 1 re-strobed three times: one frame only, after digit 0.
    f0 = frames_seen;
    strobe(1, 7'h79, 1'b0, 16);
    dwell(4'hF, 8'hFF, 3);
    strobe(1, 7'h71, 1'b0, 16);
    dwell(4'hF, 8'hFF, 3);
    strobe(1, 7'h40, 1'b0, 16);
    strobe(2, 7'h00, 1'b0, 16);
    strobe(3, 7'h6F, 1'b0, 16);
    check("restrobe_no_early_frame", frames_seen - f0, 0);
    strobe(0, 7'h06, 1'b0, 16);
    check("restrobe_one_frame", frames_seen - f0, 1);
    check_all("restrobe");

    // Timeout with no select active.
    dwell(4'hF, 8'hFF, 50);
    check("stall_early", stalled, 1'b0);
    dwell(4'hF, 8'hFF, 70);
    check("stall_set", stalled, 1'b1);
    strobe(0, 7'h3F, 1'b0, 16);
    check("stall_clear", stalled, 1'b0);

    // Randomised dwells.
    for (int n = 0; n < 150; n++) begin
      do begin
        kind = $urandom_range(0, 99);
        if (kind < 70 || kind < 85) begin
          sel = ~(4'(1) << $urandom_range(0, 3));
          seg = {1'($urandom_range(0, 1)), PAT[$urandom_range(0, 17)]};
          if ($urandom_range(0, 99) < 3) seg[6:0] = ($urandom_range(0, 1) != 0) ? 7'h55 : 7'h01;
          seg = ~seg;
          len = (kind < 70) ? $urandom_range(S + 2, S + 10) : $urandom_range(1, S - 1);
        end else begin
          sel = bad_sel[$urandom_range(0, 4)];
          seg = 8'($urandom);
          len = $urandom_range(1, 6);
        end
      end while (sel == prev_sel && seg == prev_seg);
      dwell(sel, seg, len);
    end
    dwell(4'hF, 8'hFF, 10);
    check_all("random");

    // Reset in the middle of settling digit 3.
    digit_select = 4'b0111;
    segments = ~8'h4F;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("midreset");
    check("midreset_frame", frame_done, 1'b0);
    check("midreset_stalled", stalled, 1'b0);
    digit_select = 4'hF;
    segments = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    f0 = frames_seen;
    scan(7'h3F, 7'h06, 7'h5B, 7'h4F);
    check("recover_digits", {digit3, digit2, digit1, digit0}, 32'h33323130);
    check("recover_frame", frames_seen - f0, 1);
    check_all("recover");

    repeat (20) @(negedge clk);
    check("pending_frames", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
